// File: rtl/bp_be_late_wb_queue.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : bp_be_late_wb_queue
// Brief   : Two-source late-writeback merge queue. Collects writebacks from the
//           D$ miss/uncached-load path (source 0) and the long-latency
//           divide/sqrt path (source 1) into one circular FIFO. The head is
//           presented to the scheduler, which is forced to take it once it has
//           waited force_cycles_p cycles or the queue is full.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module bp_be_late_wb_queue #(
  parameter int bp_params_p    = 0,  // 0 selects the default processor config
  parameter int els_p          = 4,  // power of two, 2..16
  parameter int force_cycles_p = 8,  // 1..255
  // The default config uses a 39-bit virtual address; other configs use 48.
  localparam int vaddr_width_lp  = (bp_params_p == 0) ? 39 : 48,
  // Register-file address/flag fields plus a payload sized off the VA width.
  localparam int wb_pkt_width_lp = vaddr_width_lp + 25
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,

  input  logic [wb_pkt_width_lp-1:0] mem_wb_pkt_i,
  input  logic                       mem_wb_v_i,
  output logic                       mem_wb_ready_and_o,

  input  logic [wb_pkt_width_lp-1:0] long_wb_pkt_i,
  input  logic                       long_wb_v_i,
  output logic                       long_wb_ready_and_o,

  output logic [wb_pkt_width_lp-1:0] late_wb_pkt_o,
  output logic                       late_wb_v_o,
  output logic                       late_wb_force_o,
  input  logic                       late_wb_yumi_i,

  output logic                       busy_o
);

  localparam int PTR_W = $clog2(els_p);
  localparam int CNT_W = $clog2(els_p + 1);
  // Depth held one bit wider than the count so count+1 never overflows.
  localparam logic [CNT_W:0] ELS_C   = (CNT_W + 1)'(els_p);
  localparam logic [7:0]     FORCE_C = 8'(force_cycles_p);

  // Payload storage is deliberately left unreset; validity comes from count.
  logic [wb_pkt_width_lp-1:0] mem_q [els_p];

  logic [PTR_W-1:0] enq_ptr_q, enq_ptr_d;
  logic [PTR_W-1:0] deq_ptr_q, deq_ptr_d;
  logic [CNT_W-1:0] count_q,   count_d;
  logic [7:0]       age_q,     age_d;

  logic             w_mem_enq;
  logic             w_long_enq;
  logic             w_deq;
  logic [PTR_W-1:0] w_long_slot;
  logic [CNT_W:0]   w_count_ext;

  assign w_count_ext = {1'b0, count_q};

  // Readies use registered occupancy only: a dequeue this cycle never frees a
  // slot for an enqueue in the same cycle. Source 0 claims the last free slot.
  assign mem_wb_ready_and_o  = reset_n_i & (w_count_ext < ELS_C);
  assign w_mem_enq           = mem_wb_v_i & mem_wb_ready_and_o;
  assign long_wb_ready_and_o = reset_n_i
                             & ((w_count_ext + {{CNT_W{1'b0}}, w_mem_enq}) < ELS_C);
  assign w_long_enq          = long_wb_v_i & long_wb_ready_and_o;

  // A same-cycle pair lands source 0 first, source 1 in the following slot.
  assign w_long_slot = enq_ptr_q + PTR_W'(w_mem_enq);

  assign late_wb_v_o     = (count_q != '0);
  assign late_wb_pkt_o   = mem_q[deq_ptr_q];
  assign w_deq           = late_wb_yumi_i & late_wb_v_o;
  // Age saturates and count cannot fall without a dequeue, so force stays
  // high for as long as the same head is waiting.
  assign late_wb_force_o = late_wb_v_o & ((age_q == FORCE_C) | (w_count_ext == ELS_C));
  assign busy_o          = late_wb_v_o;

  // Next-state for pointers, occupancy and head age.
  always_comb begin
    enq_ptr_d = enq_ptr_q + PTR_W'(w_mem_enq) + PTR_W'(w_long_enq);
    deq_ptr_d = deq_ptr_q + PTR_W'(w_deq);
    count_d   = count_q + CNT_W'(w_mem_enq) + CNT_W'(w_long_enq) - CNT_W'(w_deq);
    age_d     = age_q;
    if (w_deq || !late_wb_v_o) begin
      age_d = '0;
    end else if (age_q != FORCE_C) begin
      age_d = age_q + 8'd1;
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      enq_ptr_q <= '0;
      deq_ptr_q <= '0;
      count_q   <= '0;
      age_q     <= '0;
    end else begin
      enq_ptr_q <= enq_ptr_d;
      deq_ptr_q <= deq_ptr_d;
      count_q   <= count_d;
      age_q     <= age_d;
    end
  end

  // Payload writes; readies are low in reset so nothing is written then.
  always_ff @(posedge clk_i) begin
    if (w_mem_enq) begin
      mem_q[enq_ptr_q] <= mem_wb_pkt_i;
    end
    if (w_long_enq) begin
      mem_q[w_long_slot] <= long_wb_pkt_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bp_be_late_wb_queue.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_bp_be_late_wb_queue
// Brief   : Self-checking bench for bp_be_late_wb_queue: hand-written vector
//           table, directed force/stream sequences and random traffic checked
//           against a queue-based reference model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tb_bp_be_late_wb_queue;

  localparam int W   = 64;
  localparam int ELS = 4;
  localparam int F   = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] mem_pkt, long_pkt, out_pkt;
  logic         mem_v, long_v, mem_rdy, long_rdy;
  logic         out_v, out_force, yumi, busy;

  int errors = 0;
  int checks = 0;
  int proto_errs = 0;

  // Reference model: ordered list of accepted packets and the head's wait time.
  logic [W-1:0] q[$];
  int           age = 0;

  always #5 clk = ~clk;

  bp_be_late_wb_queue #(.bp_params_p(0), .els_p(ELS), .force_cycles_p(F)) dut (
    .clk_i              (clk),
    .reset_n_i          (reset_n),
    .mem_wb_pkt_i       (mem_pkt),
    .mem_wb_v_i         (mem_v),
    .mem_wb_ready_and_o (mem_rdy),
    .long_wb_pkt_i      (long_pkt),
    .long_wb_v_i        (long_v),
    .long_wb_ready_and_o(long_rdy),
    .late_wb_pkt_o      (out_pkt),
    .late_wb_v_o        (out_v),
    .late_wb_force_o    (out_force),
    .late_wb_yumi_i     (yumi),
    .busy_o             (busy)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply inputs away from the clock edge, then compare against the model.
  task automatic drive(input logic rn, input logic mv, input logic [W-1:0] mp,
                       input logic lv, input logic [W-1:0] lp, input logic y);
    int   n;
    logic em, el, ev, ef;
    @(negedge clk);
    reset_n = rn; mem_v = mv; mem_pkt = mp; long_v = lv; long_pkt = lp; yumi = y;
    #1;
    n  = q.size();
    em = rn && (n < ELS);
    el = rn && ((n + ((mv && em) ? 1 : 0)) < ELS);
    ev = (n != 0);
    ef = ev && ((age >= F) || (n == ELS));
    chk("mdl_mem_rdy",  W'(mem_rdy),   W'(em));
    chk("mdl_long_rdy", W'(long_rdy),  W'(el));
    chk("mdl_v",        W'(out_v),     W'(ev));
    chk("mdl_busy",     W'(busy),      W'(ev));
    chk("mdl_force",    W'(out_force), W'(ef));
    if (ev) chk("mdl_pkt", out_pkt, q[0]);
  endtask

  // Advance the clock and apply the same cycle's effects to the model.
  task automatic tick();
    int   n;
    logic ev, am, al;
    @(posedge clk);
    if (!reset_n) begin
      q.delete();
      age = 0;
    end else begin
      n  = q.size();
      ev = (n != 0);
      am = mem_v && (n < ELS);
      al = long_v && ((n + (am ? 1 : 0)) < ELS);
      if (yumi && !ev) begin
        proto_errs++;
        $display("NOTE protocol: yumi asserted while queue empty at %0t", $time);
      end
      if (yumi && ev) begin
        void'(q.pop_front());
        age = 0;
      end else if (!ev) begin
        age = 0;
      end else if (age < F) begin
        age++;
      end
      if (am) q.push_back(mem_pkt);
      if (al) q.push_back(long_pkt);
    end
  endtask

  typedef struct {
    logic         rn, mv;
    logic [W-1:0] mp;
    logic         lv;
    logic [W-1:0] lp;
    logic         y;
    logic         ev, ef, emr, elr;
    logic [W-1:0] epkt;
  } vec_t;

  localparam logic [W-1:0] PA = 64'hAAAA_0000_0000_000A;
  localparam logic [W-1:0] PB = 64'hBBBB_0000_0000_000B;
  localparam logic [W-1:0] PC = 64'hCCCC_0000_0000_000C;
  localparam logic [W-1:0] PD = 64'hDDDD_0000_0000_000D;
  localparam logic [W-1:0] PE = 64'hEEEE_0000_0000_000E;
  localparam logic [W-1:0] PG = 64'h6666_0000_0000_0006;
  localparam logic [W-1:0] PH = 64'h7777_0000_0000_0007;

  vec_t tbl[13];

  initial begin
    int pb;
    reset_n = 1'b0; mem_v = 1'b0; long_v = 1'b0; yumi = 1'b0;
    mem_pkt = '0; long_pkt = '0;

    //          rn  mv  mp  lv  lp  y   ev  ef  mr  lr  pkt
    tbl[0]  = '{0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0 };  // in reset
    tbl[1]  = '{1,  1,  PA, 0,  0,  0,  0,  0,  1,  1,  0 };  // enqueue A
    tbl[2]  = '{1,  0,  0,  0,  0,  1,  1,  0,  1,  1,  PA};  // A visible, take it
    tbl[3]  = '{1,  0,  0,  0,  0,  0,  0,  0,  1,  1,  0 };  // empty again
    tbl[4]  = '{1,  1,  PB, 1,  PC, 0,  0,  0,  1,  1,  0 };  // dual enqueue B,C
    tbl[5]  = '{1,  1,  PD, 0,  0,  0,  1,  0,  1,  1,  PB};  // count 2 -> 3
    tbl[6]  = '{1,  1,  PE, 1,  PG, 0,  1,  0,  1,  0,  PB};  // count 3: mem wins slot
    tbl[7]  = '{1,  0,  0,  0,  0,  0,  1,  1,  0,  0,  PB};  // full -> force
    tbl[8]  = '{1,  0,  0,  0,  0,  1,  1,  1,  0,  0,  PB};  // take B
    tbl[9]  = '{0,  1,  PH, 0,  0,  0,  1,  0,  0,  0,  PC};  // reset with count 3
    tbl[10] = '{1,  0,  0,  0,  0,  0,  0,  0,  1,  1,  0 };  // flushed
    tbl[11] = '{1,  0,  0,  0,  0,  1,  0,  0,  1,  1,  0 };  // yumi while empty
    tbl[12] = '{1,  0,  0,  0,  0,  0,  0,  0,  1,  1,  0 };  // no state change

    // Bring the design out of an unknown state before any checks.
    repeat (2) @(posedge clk);
    q.delete();
    age = 0;

    // Table-driven vectors.
    for (int i = 0; i < 13; i++) begin
      pb = proto_errs;
      drive(tbl[i].rn, tbl[i].mv, tbl[i].mp, tbl[i].lv, tbl[i].lp, tbl[i].y);
      chk($sformatf("t%0d_v", i),        W'(out_v),     W'(tbl[i].ev));
      chk($sformatf("t%0d_busy", i),     W'(busy),      W'(tbl[i].ev));
      chk($sformatf("t%0d_force", i),    W'(out_force), W'(tbl[i].ef));
      chk($sformatf("t%0d_mem_rdy", i),  W'(mem_rdy),   W'(tbl[i].emr));
      chk($sformatf("t%0d_long_rdy", i), W'(long_rdy),  W'(tbl[i].elr));
      if (tbl[i].ev) chk($sformatf("t%0d_pkt", i), out_pkt, tbl[i].epkt);
      tick();
      if (i == 11) chk("t11_proto_flag", W'(proto_errs), W'(pb + 1));
    end

    // Head-age forcing: two entries, hold the first until forced, then the
    // second must start its own wait from zero.
    drive(1, 1, 64'h1111, 1, 64'h2222, 0); tick();
    for (int k = 1; k <= 10; k++) begin
      drive(1, 0, 0, 0, 0, 0);
      chk($sformatf("age1_force_k%0d", k), W'(out_force), W'(k >= 9));
      tick();
    end
    drive(1, 0, 0, 0, 0, 1);
    chk("age1_force_at_yumi", W'(out_force), W'(1));
    tick();
    for (int k = 1; k <= 9; k++) begin
      drive(1, 0, 0, 0, 0, (k == 9));
      chk($sformatf("age2_force_k%0d", k), W'(out_force), W'(k >= 9));
      chk($sformatf("age2_pkt_k%0d", k), out_pkt, 64'h2222);
      tick();
    end
    drive(1, 0, 0, 0, 0, 0);
    chk("age_drained_v", W'(out_v), W'(0));
    tick();

    // Continuous dual enqueue with one dequeue per cycle: wraps pointers and
    // checks the interleaved ordering through the model.
    for (int c = 0; c < 20; c++) begin
      drive(1, 1, 64'h1000_0000_0000_0000 | W'(c), 1, 64'h2000_0000_0000_0000 | W'(c),
            (q.size() != 0));
      tick();
    end
    for (int c = 0; c < 8 && q.size() != 0; c++) begin
      drive(1, 0, 0, 0, 0, 1);
      tick();
    end
    drive(1, 0, 0, 0, 0, 0);
    chk("stream_drained_v", W'(out_v), W'(0));
    tick();

    // Randomized traffic against the model, including occasional resets.
    for (int c = 0; c < 800; c++) begin
      drive(($urandom_range(0, 59) != 0),
            ($urandom_range(0, 2) != 0), {$urandom, $urandom},
            ($urandom_range(0, 1) != 0), {$urandom, $urandom},
            (($urandom_range(0, 2) != 0) && (q.size() != 0)));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
